// File: rtl/writeback_stage.sv
// Write-back stage: picks load data or ALU result for the register file.
// Both the data and the destination index are registered.
module writeback_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      resetl,
  input  logic                      Mem2Reg_WB,
  input  logic [REG_ADDR_WIDTH-1:0] RD_WB,
  input  logic [DATA_WIDTH-1:0]     ALUout_WB,
  input  logic [DATA_WIDTH-1:0]     ReadData_WB,
  output logic [REG_ADDR_WIDTH-1:0] RD,
  output logic [DATA_WIDTH-1:0]     MemtoRegOut
);

  logic [REG_ADDR_WIDTH-1:0] rd_d, rd_q;
  logic [DATA_WIDTH-1:0]     wb_data_d, wb_data_q;

  // RD = 0 is forwarded as-is; the register file drops writes to XZR.
  always_comb begin
    rd_d      = RD_WB;
    wb_data_d = ALUout_WB;
    if (Mem2Reg_WB) begin
      wb_data_d = ReadData_WB;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetl) begin
      rd_q      <= '0;
      wb_data_q <= '0;
    end else begin
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign RD          = rd_q;
  assign MemtoRegOut = wb_data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, source select, latency,
// reset mid-stream and X isolation on the unselected data input.
module tb_writeback_stage;

  logic        clk;
  logic        resetl;
  logic        Mem2Reg_WB;
  logic [4:0]  RD_WB;
  logic [63:0] ALUout_WB;
  logic [63:0] ReadData_WB;
  logic [4:0]  RD;
  logic [63:0] MemtoRegOut;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_stage #(
    .DATA_WIDTH    (64),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk        (clk),
    .resetl     (resetl),
    .Mem2Reg_WB (Mem2Reg_WB),
    .RD_WB      (RD_WB),
    .ALUout_WB  (ALUout_WB),
    .ReadData_WB(ReadData_WB),
    .RD         (RD),
    .MemtoRegOut(MemtoRegOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetl      = 1'b0;
    Mem2Reg_WB  = 1'b0;
    RD_WB       = 5'd9;
    ALUout_WB   = 64'd5;
    ReadData_WB = 64'd0;

    // Reset held for two edges with arbitrary inputs
    tick();
    tick();
    check("rst_rd",   {59'd0, RD}, 64'd0);
    check("rst_data", MemtoRegOut, 64'd0);

    // Load path
    resetl = 1'b1; Mem2Reg_WB = 1'b1; RD_WB = 5'd3; ReadData_WB = 64'd56; ALUout_WB = 64'd0;
    tick();
    check("load_rd",   {59'd0, RD}, 64'd3);
    check("load_data", MemtoRegOut, 64'd56);

    // ALU path
    Mem2Reg_WB = 1'b0; RD_WB = 5'd7; ALUout_WB = 64'd98; ReadData_WB = 64'd0;
    tick();
    check("alu_rd",   {59'd0, RD}, 64'd7);
    check("alu_data", MemtoRegOut, 64'd98);

    // Select isolation
    ALUout_WB = 64'hAAAA_AAAA_AAAA_AAAA; ReadData_WB = 64'h5555_5555_5555_5555;
    RD_WB = 5'd31; Mem2Reg_WB = 1'b1;
    tick();
    check("iso_mem_data", MemtoRegOut, 64'h5555_5555_5555_5555);
    check("iso_mem_rd",   {59'd0, RD}, 64'd31);
    Mem2Reg_WB = 1'b0;
    #2;
    check("iso_hold_data", MemtoRegOut, 64'h5555_5555_5555_5555);
    tick();
    check("iso_alu_data", MemtoRegOut, 64'hAAAA_AAAA_AAAA_AAAA);
    check("iso_alu_rd",   {59'd0, RD}, 64'd31);

    // Latency: a mid-cycle change is invisible until the next edge
    ALUout_WB = 64'd1;
    tick();
    check("lat_first", MemtoRegOut, 64'd1);
    ALUout_WB = 64'd2;
    #3;
    check("lat_hold", MemtoRegOut, 64'd1);
    tick();
    check("lat_next", MemtoRegOut, 64'd2);

    // Reset mid-stream
    RD_WB = 5'd7; ALUout_WB = 64'd98; Mem2Reg_WB = 1'b0;
    tick();
    check("pre_rst_rd",   {59'd0, RD}, 64'd7);
    check("pre_rst_data", MemtoRegOut, 64'd98);
    resetl = 1'b0;
    #2;
    check("rst_async_hold", MemtoRegOut, 64'd98);
    tick();
    check("mid_rst_rd",   {59'd0, RD}, 64'd0);
    check("mid_rst_data", MemtoRegOut, 64'd0);
    resetl = 1'b1;
    #2;
    check("rel_hold_data", MemtoRegOut, 64'd0);
    tick();
    check("reload_rd",   {59'd0, RD}, 64'd7);
    check("reload_data", MemtoRegOut, 64'd98);

    // Unknown on the unselected input must not leak
    Mem2Reg_WB = 1'b1; ALUout_WB = 'x; ReadData_WB = 64'd123;
    tick();
    check("x_alu_unsel", MemtoRegOut, 64'd123);
    Mem2Reg_WB = 1'b0; ALUout_WB = 64'd77; ReadData_WB = 'x;
    tick();
    check("x_mem_unsel", MemtoRegOut, 64'd77);

    // Full-width pass-through and RD = 0 forwarding
    Mem2Reg_WB = 1'b1; ReadData_WB = 64'h8000_0000_0000_0001; RD_WB = 5'd0;
    tick();
    check("full_width", MemtoRegOut, 64'h8000_0000_0000_0001);
    check("xzr_rd",     {59'd0, RD}, 64'd0);
    Mem2Reg_WB = 1'b0; ALUout_WB = 64'hFFFF_FFFF_FFFF_FFFF; RD_WB = 5'd16;
    tick();
    check("all_ones", MemtoRegOut, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rd_msb",   {59'd0, RD}, 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
